// File: rtl/input_capture_ctrl_if.sv
// Pin, timer, configuration and read-port bundle of the input-capture control block.
// slave is the capture controller side, master is the register-file / stimulus side.
interface input_capture_ctrl_if;
  logic        ins;
  logic [2:0]  icm;
  logic [1:0]  ictmr;
  logic [1:0]  ici;
  logic [15:0] t_val_bi_0;
  logic [15:0] t_val_bi_1;
  logic        rd_i;
  logic [31:0] icbuf;
  logic        icbne;
  logic        icov;
  logic        ic_int;

  modport slave (
    input  ins, icm, ictmr, ici, t_val_bi_0, t_val_bi_1, rd_i,
    output icbuf, icbne, icov, ic_int
  );

  modport master (
    output ins, icm, ictmr, ici, t_val_bi_0, t_val_bi_1, rd_i,
    input  icbuf, icbne, icov, ic_int
  );
endinterface

// File: rtl/input_capture_ctrl.sv
// Input-capture front end: pin synchroniser, edge/prescale qualification, FWFT capture FIFO,
// overflow flag and capture interrupt. Define IC_CAP32_EN to enable 32-bit cascade captures.
module input_capture_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input_capture_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  logic        sync_1;
  logic        sync_2;
  logic        prev;
  logic        rise;
  logic        fall;
  logic        any_edge;
  logic        mode_off;
  logic        prescaled;
  logic        pre_hit;
  logic        capture_event;
  logic [3:0]  pre_cnt;
  logic [2:0]  icm_prev;
  logic [31:0] entry;

  logic [31:0] mem [DEPTH];
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;
  ptr_t        rd_ptr_n;
  ptr_t        wr_ptr_n;
  cnt_t        count;
  cnt_t        count_n;
  logic        full;
  logic        pop;
  logic        push;
  logic        overflow;
  logic [31:0] head_n;
  logic [31:0] icbuf_q;
  logic        icov_q;
  logic        ic_int_q;
  logic [2:0]  int_cnt;
  logic [2:0]  int_next;
  logic [2:0]  int_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_1 <= bus.ins;
      sync_2 <= sync_1;
      prev   <= sync_2;
    end
  end

  assign rise      = sync_2 & ~prev;
  assign fall      = ~sync_2 & prev;
  assign any_edge  = sync_2 ^ prev;
  assign mode_off  = (bus.icm == 3'b000) || (bus.icm[2:1] == 2'b11);
  assign prescaled = (bus.icm == 3'b100) || (bus.icm == 3'b101);

  always_comb begin
    capture_event = 1'b0;
    pre_hit       = 1'b0;
    case (bus.icm)
      3'b001: capture_event = any_edge;
      3'b010: capture_event = fall;
      3'b011: capture_event = rise;
      3'b100: begin
        pre_hit       = (pre_cnt == 4'd3);
        capture_event = rise & pre_hit;
      end
      3'b101: begin
        pre_hit       = (pre_cnt == 4'd15);
        capture_event = rise & pre_hit;
      end
      default: capture_event = 1'b0;
    endcase
  end

  // A mode change restarts the prescaler so stale counts never leak into the new mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= 4'd0;
      icm_prev <= 3'b000;
    end else begin
      icm_prev <= bus.icm;
      if ((bus.icm != icm_prev) || mode_off) begin
        pre_cnt <= 4'd0;
      end else if (prescaled && rise) begin
        pre_cnt <= pre_hit ? 4'd0 : pre_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    entry = {16'h0000, bus.t_val_bi_0};
`ifdef IC_CAP32_EN
    case (bus.ictmr)
      2'b01:   entry = {16'h0000, bus.t_val_bi_1};
      2'b10:   entry = {bus.t_val_bi_1, bus.t_val_bi_0};
      default: entry = {16'h0000, bus.t_val_bi_0};
    endcase
`else
    if (bus.ictmr == 2'b01) begin
      entry = {16'h0000, bus.t_val_bi_1};
    end
`endif
  end

  assign full     = (count == FULL_CNT);
  assign pop      = bus.rd_i && (count != '0) && !mode_off;
  assign push     = capture_event && (!full || pop);
  assign overflow = capture_event && full && !pop;

  always_comb begin
    rd_ptr_n = pop  ? rd_ptr + ptr_t'(1) : rd_ptr;
    wr_ptr_n = push ? wr_ptr + ptr_t'(1) : wr_ptr;
    count_n  = count;
    case ({push, pop})
      2'b10:   count_n = count + cnt_t'(1);
      2'b01:   count_n = count - cnt_t'(1);
      default: count_n = count;
    endcase
  end

  // The head register is loaded with the post-update head, bypassing the write when the
  // incoming entry lands in the slot that becomes the new head.
  always_comb begin
    head_n = 32'h0000_0000;
    if (!mode_off && (count_n != '0)) begin
      if (push && (rd_ptr_n == wr_ptr)) begin
        head_n = entry;
      end else begin
        head_n = mem[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      icbuf_q <= 32'h0000_0000;
      icov_q  <= 1'b0;
    end else if (mode_off) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      icbuf_q <= 32'h0000_0000;
      icov_q  <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr_n;
      wr_ptr  <= wr_ptr_n;
      count   <= count_n;
      icbuf_q <= head_n;
      if (overflow) begin
        icov_q <= 1'b1;
      end
    end
  end

  assign int_target = {1'b0, bus.ici} + 3'd1;
  assign int_next   = int_cnt + 3'd1;

  // Only captures that actually reach the FIFO advance the interrupt count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt  <= 3'd0;
      ic_int_q <= 1'b0;
    end else begin
      ic_int_q <= 1'b0;
      if (mode_off) begin
        int_cnt <= 3'd0;
      end else if (push) begin
        if (int_next == int_target) begin
          int_cnt  <= 3'd0;
          ic_int_q <= 1'b1;
        end else begin
          int_cnt <= int_next;
        end
      end
    end
  end

  assign bus.icbuf  = icbuf_q;
  assign bus.icbne  = (count != '0);
  assign bus.icov   = icov_q;
  assign bus.ic_int = ic_int_q;

endmodule

// File: tb/tb_input_capture_ctrl.sv
// Scoreboard bench for input_capture_ctrl: stored captures are queued as expected entries and
// a monitor compares them against icbuf whenever the bench pops the FIFO.
module tb_input_capture_ctrl;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   int_pulses = 0;
  int   base;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] cap32_exp;

  input_capture_ctrl_if bus ();

  input_capture_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pin(input logic lvl, input logic [15:0] t0v, input logic [15:0] t1v);
    bus.t_val_bi_0 = t0v;
    bus.t_val_bi_1 = t1v;
    bus.ins        = lvl;
    tick(3);
  endtask

  task automatic toggle_pin(input logic [15:0] t0v);
    set_pin(~bus.ins, t0v, 16'hFFFF);
  endtask

  task automatic pop_n(input int n);
    bus.rd_i = 1'b1;
    tick(n);
    bus.rd_i = 1'b0;
  endtask

  // Monitor: every pop strobe is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.ic_int === 1'b1) int_pulses++;
    if (rst_n === 1'b1 && bus.rd_i === 1'b1) begin
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check_output("pop_valid", 32'(bus.icbne), 32'd1);
        check_output("pop_data", bus.icbuf, mon_exp);
      end else begin
        check_output("pop_empty", 32'(bus.icbne), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.ins        = 1'b0;
    bus.icm        = 3'b000;
    bus.ictmr      = 2'b00;
    bus.ici        = 2'b00;
    bus.t_val_bi_0 = 16'h0000;
    bus.t_val_bi_1 = 16'h0000;
    bus.rd_i       = 1'b0;
    tick(2);
    check_output("rst_icbuf", bus.icbuf, 32'h0);
    check_output("rst_icbne", 32'(bus.icbne), 32'd0);
    check_output("rst_icov", 32'(bus.icov), 32'd0);
    check_output("rst_ic_int", 32'(bus.ic_int), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single rising capture, three-clock latency, interrupt on every capture.
    bus.icm = 3'b011;
    tick(2);
    set_pin(1'b1, 16'h0100, 16'h0777);
    check_output("t1_icbne", 32'(bus.icbne), 32'd1);
    check_output("t1_icbuf", bus.icbuf, 32'h0000_0100);
    check_output("t1_ic_int", 32'(bus.ic_int), 32'd1);
    exp_q.push_back(32'h0000_0100);
    tick(1);
    check_output("t1_int_one_cycle", 32'(bus.ic_int), 32'd0);
    pop_n(1);
    check_output("t1_empty_icbne", 32'(bus.icbne), 32'd0);
    check_output("t1_empty_icbuf", bus.icbuf, 32'h0);
    set_pin(1'b0, 16'h0200, 16'h0000);
    check_output("t1_fall_ignored", 32'(bus.icbne), 32'd0);

    // Every-edge mode overflow: fifth capture discarded, FIFO untouched.
    bus.ici = 2'd3;
    bus.icm = 3'b001;
    tick(2);
    base = int_pulses;
    for (int i = 1; i <= 5; i++) begin
      toggle_pin(16'(i));
      if (i <= 4) exp_q.push_back(32'(i));
      check_output("t2_icov", 32'(bus.icov), (i == 5) ? 32'd1 : 32'd0);
    end
    check_output("t2_head", bus.icbuf, 32'h1);
    check_output("t2_int_count", 32'(int_pulses - base), 32'd1);
    pop_n(4);
    check_output("t2_drained_icbne", 32'(bus.icbne), 32'd0);
    check_output("t2_drained_icbuf", bus.icbuf, 32'h0);
    check_output("t2_icov_sticky", 32'(bus.icov), 32'd1);
    pop_n(1);
    toggle_pin(16'd6);
    exp_q.push_back(32'd6);
    toggle_pin(16'd7);
    exp_q.push_back(32'd7);
    check_output("t2_capture_with_icov", 32'(bus.icbne), 32'd1);
    check_output("t2_icov_still", 32'(bus.icov), 32'd1);

    // Switching off flushes on the next clock and clears overflow.
    bus.icm = 3'b000;
    tick(1);
    exp_q.delete();
    check_output("t6_off_icbne", 32'(bus.icbne), 32'd0);
    check_output("t6_off_icov", 32'(bus.icov), 32'd0);
    check_output("t6_off_icbuf", bus.icbuf, 32'h0);
    toggle_pin(16'd8);
    check_output("t6_off_no_capture", 32'(bus.icbne), 32'd0);

    // Full FIFO with capture and pop on the same edge.
    bus.icm = 3'b001;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      toggle_pin(16'h0010 + 16'(i));
      exp_q.push_back(32'h0010 + 32'(i));
    end
    check_output("t3_full_icov", 32'(bus.icov), 32'd0);
    check_output("t3_full_head", bus.icbuf, 32'h10);
    bus.t_val_bi_0 = 16'h0014;
    bus.ins        = ~bus.ins;
    tick(2);
    bus.rd_i = 1'b1;
    exp_q.push_back(32'h14);
    tick(1);
    bus.rd_i = 1'b0;
    check_output("t3_no_overflow", 32'(bus.icov), 32'd0);
    check_output("t3_head_advanced", bus.icbuf, 32'h11);
    pop_n(4);
    check_output("t3_drained", 32'(bus.icbne), 32'd0);

    // Divide-by-4 rise prescaler selecting timer 1.
    bus.icm   = 3'b100;
    bus.ictmr = 2'b01;
    set_pin(1'b0, 16'h5555, 16'h00AA);
    for (int i = 0; i < 8; i++) begin
      set_pin(1'b1, 16'h5555, 16'h00AA);
      if (i == 3 || i == 7) exp_q.push_back(32'h0000_00AA);
      check_output("t4_icbne", 32'(bus.icbne), (i >= 3) ? 32'd1 : 32'd0);
      set_pin(1'b0, 16'h5555, 16'h00AA);
    end
    pop_n(2);
    check_output("t4_two_entries", 32'(bus.icbne), 32'd0);

    // Interrupt every third falling-edge capture.
    bus.icm = 3'b000;
    tick(2);
    bus.ici   = 2'd2;
    bus.ictmr = 2'b00;
    bus.icm   = 3'b010;
    tick(2);
    base = int_pulses;
    for (int i = 0; i < 6; i++) begin
      set_pin(1'b1, 16'h0000, 16'h0000);
      set_pin(1'b0, 16'h0050 + 16'(i), 16'h0000);
      exp_q.push_back(32'h0050 + 32'(i));
      check_output("t5_ic_int", 32'(bus.ic_int), (i == 2 || i == 5) ? 32'd1 : 32'd0);
      pop_n(1);
    end
    check_output("t5_int_count", 32'(int_pulses - base), 32'd2);

    // Cascade selection (32-bit only when IC_CAP32_EN), and ictmr=11 acting as timer 0.
    bus.icm = 3'b011;
    tick(2);
    bus.ictmr = 2'b10;
`ifdef IC_CAP32_EN
    cap32_exp = 32'h1234_5678;
`else
    cap32_exp = 32'h0000_5678;
`endif
    set_pin(1'b1, 16'h5678, 16'h1234);
    check_output("t6_ictmr10", bus.icbuf, cap32_exp);
    exp_q.push_back(cap32_exp);
    pop_n(1);
    set_pin(1'b0, 16'h0000, 16'h0000);
    bus.ictmr = 2'b11;
    set_pin(1'b1, 16'h0ABC, 16'h9999);
    check_output("t6_ictmr11", bus.icbuf, 32'h0000_0ABC);
    exp_q.push_back(32'h0000_0ABC);
    pop_n(1);

    // Asynchronous reset in the middle of a capture with overflow set.
    bus.icm   = 3'b001;
    bus.ictmr = 2'b00;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      toggle_pin(16'h0060 + 16'(i));
    end
    check_output("t6_pre_rst_icov", 32'(bus.icov), 32'd1);
    bus.ins = ~bus.ins;
    tick(1);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_icbuf", bus.icbuf, 32'h0);
    check_output("t6_rst_icbne", 32'(bus.icbne), 32'd0);
    check_output("t6_rst_icov", 32'(bus.icov), 32'd0);
    check_output("t6_rst_ic_int", 32'(bus.ic_int), 32'd0);
    bus.ins = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check_output("t6_pending_lost", 32'(bus.icbne), 32'd0);

    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
